bin_to_bcd_seq: RTL and testbench
=================================

// Module: bin_to_bcd_seq
// PURPOSE
//  Sequential, parametrised binary-to-BCD converter (shift-and-add-3, one bit per clock).
//  Successor to the combinational 16-bit converter. Adds generic width and digit count,
//  optional two's-complement input, a start/done handshake and an overflow flag.
//  Sits between arithmetic/counter logic and the 7-segment display drivers.
// PARAMETERS
//  BIN_WIDTH  16  width of binary input; conversion takes BIN_WIDTH shift cycles (>=2)
//  DIGITS      5  number of BCD digits in the result; ceil(BIN_WIDTH*log10(2)) is lossless
// PORTS
//  clk        in   1               system clock, rising edge
//  reset      in   1               synchronous, active-high reset
//  start      in   1               request a conversion; sampled only when busy=0
//  binNum     in   BIN_WIDTH       operand; captured on the edge that accepts start
//  signedIn   in   1               1: binNum is two's complement; 0: unsigned
//  busy       out  1               high while the converter is in SHIFT
//  done       out  1               one-cycle pulse; result outputs valid from this cycle
//  bcd        out  4*DIGITS        result; digit k in bcd[4k+3:4k], k=0 is ones
//  negative   out  1               sign of the last result (1 only if signedIn and MSB=1)
//  overflow   out  1               last result lost a nonzero carry out of the top digit
// BEHAVIOUR
//  - One clock (clk). Reset is synchronous and active-high: a rising edge of clk with
//    reset=1 forces state IDLE, busy=0, done=0, bcd=0, negative=0, overflow=0, count=0,
//    and clears the working registers. Reset has priority over start and over SHIFT.
//  - States: IDLE, SHIFT, DONE.
//    IDLE  -> SHIFT on start=1; DONE -> SHIFT on start=1; DONE -> IDLE otherwise.
//    SHIFT -> DONE when the BIN_WIDTH-th shift completes.
//  - Accept edge: capture mag = (signedIn & binNum[MSB]) ? -binNum : binNum,
//    computed BIN_WIDTH bits wide, unsigned. -2^(BIN_WIDTH-1) gives
//    magnitude 2^(BIN_WIDTH-1), which is exact.
//    Latch sign. Clear the working digits and the sticky overflow. Set count=BIN_WIDTH.
//  - Each SHIFT edge does the following:
//    - Add 3 to every working digit greater than 4 (all digits in parallel).
//    - Shift {digits, mag} left by 1; the next mag bit enters the ones digit, MSB first.
//    - OR the bit shifted out of the top digit into sticky overflow.
//    - Decrement count.
//  - Final shift edge (count==1): the post-shift digits load bcd, the sign loads negative,
//    and the sticky flag loads overflow. done=1 and busy=0 for the next cycle (DONE).
//  - Latency: start accepted at edge 0 -> busy=1 after edges 1..BIN_WIDTH-1; done=1 in
//    the cycle after edge BIN_WIDTH, exactly one cycle wide.
//  - bcd/negative/overflow change only at the final shift edge or on reset. They hold
//    through later conversions until the next done.
//  - start while busy=1 is ignored (no queueing, no restart, operand not recaptured).
//  - start while in DONE (busy=0) is accepted: back-to-back conversions,
//    throughput = BIN_WIDTH+1 cycles.
//  - overflow=1 leaves bcd holding the low DIGITS digits of the true value (modulo 10^DIGITS).
//  - Reset mid-SHIFT aborts the conversion: no done pulse, outputs return to 0.
//  - All digit arithmetic is 4-bit. The counter is $clog2(BIN_WIDTH+1) bits wide.
// TESTING
//  1. Defaults, unsigned 0xFFFF, start at edge 0 -> done only in cycle after edge 16;
//     bcd=0x65535, neg=0, ovf=0.
//  2. Defaults, signedIn=1, binNum=0x8000 -> bcd=0x32768, negative=1. Also 0xFFFF signed
//     -> bcd=0x00001, negative=1. Also 0x0000 -> all zero, negative=0.
//  3. start pulsed again at edges 3 and 10 of a conversion -> ignored; one done only;
//     result is for the first operand.
//  4. start held high across DONE, operands 1234 then 9 -> two done pulses 17 cycles apart;
//     bcd=0x01234 then 0x00009.
//  5. reset=1 at edge 8 of a conversion of 0xFFFF -> no done; all outputs 0;
//     next start converts normally.
//  6. BIN_WIDTH=8, DIGITS=2, binNum=255 unsigned -> done after edge 8; bcd=0x55, overflow=1.
//     Also 99 -> bcd=0x99, overflow=0.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_seq
// Brief    : Sequential binary-to-BCD converter (shift-and-add-3, one bit per
//            clock) with optional two's-complement input and overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq #(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS    = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  binNum,
  input  logic                  signedIn,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  negative,
  output logic                  overflow
);

  localparam int CW = $clog2(BIN_WIDTH + 1);
  localparam logic [CW-1:0]        c_one        = CW'(1);
  localparam logic [CW-1:0]        c_count_init = CW'(BIN_WIDTH);
  localparam logic [BIN_WIDTH-1:0] c_bin_one    = {{(BIN_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [BIN_WIDTH-1:0]   r_mag;
  logic [4*DIGITS-1:0]    r_digits;
  logic                   r_sign;
  logic                   r_sticky;
  logic [CW-1:0]          r_count;

  logic                   w_accept;
  logic                   w_last;
  logic                   w_neg_in;
  logic [BIN_WIDTH-1:0]   w_mag_in;
  logic [4*DIGITS-1:0]    w_adj;
  logic [4*DIGITS-1:0]    w_shift;
  logic                   w_carry;

  assign w_accept = start && (r_state != S_SHIFT);
  assign w_last   = (r_state == S_SHIFT) && (r_count == c_one);
  assign w_neg_in = signedIn & binNum[BIN_WIDTH-1];
  // Negating the most negative value wraps to 2^(BIN_WIDTH-1), read as unsigned.
  assign w_mag_in = w_neg_in ? ((~binNum) + c_bin_one) : binNum;

  assign busy = (r_state == S_SHIFT);
  assign done = (r_state == S_DONE);

  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      assign w_adj[4*k+3:4*k] = (r_digits[4*k+3:4*k] > 4'd4) ?
                                (r_digits[4*k+3:4*k] + 4'd3) : r_digits[4*k+3:4*k];
    end
  endgenerate

  assign w_shift = {w_adj[4*DIGITS-2:0], r_mag[BIN_WIDTH-1]};
  assign w_carry = w_adj[4*DIGITS-1];

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_SHIFT;
      S_SHIFT: if (r_count == c_one) w_next = S_DONE;
      S_DONE:  w_next = start ? S_SHIFT : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mag    <= '0;
      r_digits <= '0;
      r_sign   <= 1'b0;
      r_sticky <= 1'b0;
      r_count  <= '0;
      bcd      <= '0;
      negative <= 1'b0;
      overflow <= 1'b0;
    end else if (w_accept) begin
      r_mag    <= w_mag_in;
      r_sign   <= w_neg_in;
      r_digits <= '0;
      r_sticky <= 1'b0;
      r_count  <= c_count_init;
    end else if (r_state == S_SHIFT) begin
      r_digits <= w_shift;
      r_mag    <= {r_mag[BIN_WIDTH-2:0], 1'b0};
      r_sticky <= r_sticky | w_carry;
      r_count  <= r_count - c_one;
      if (w_last) begin
        bcd      <= w_shift;
        negative <= r_sign;
        overflow <= r_sticky | w_carry;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin_to_bcd_seq
// Brief    : Self-checking bench for bin_to_bcd_seq (16/5 and 8/2 instances)
//            against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        reset;
  logic        start16, sgn16, start8, sgn8;
  logic [15:0] bin16;
  logic [7:0]  bin8;
  logic        busy16, done16, neg16, ovf16;
  logic        busy8, done8, neg8, ovf8;
  logic [19:0] bcd16;
  logic [7:0]  bcd8;

  int n_tests = 0;
  int n_fail  = 0;

  bin_to_bcd_seq #(.BIN_WIDTH(16), .DIGITS(5)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .binNum(bin16), .signedIn(sgn16),
    .busy(busy16), .done(done16), .bcd(bcd16), .negative(neg16), .overflow(ovf16)
  );

  bin_to_bcd_seq #(.BIN_WIDTH(8), .DIGITS(2)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .binNum(bin8), .signedIn(sgn8),
    .busy(busy8), .done(done8), .bcd(bcd8), .negative(neg8), .overflow(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: magnitude as an integer, then decimal digits by division.
  task automatic model(input int width, input int digits, input logic [15:0] bin,
                       input bit sgn, output logic [31:0] ebcd, output bit eneg,
                       output bit eovf);
    longint mask, v, mag, lim, r;
    mask = (64'd1 << width) - 1;
    v    = longint'(bin) & mask;
    eneg = sgn && bin[width-1];
    mag  = eneg ? (((64'd1 << width) - v) & mask) : v;
    lim  = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    eovf = (mag >= lim);
    r    = mag % lim;
    ebcd = '0;
    for (int i = 0; i < digits; i++) begin
      ebcd[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
  endtask

  task automatic run_conv(input bit w8, input logic [15:0] bin, input bit sgn, input string tag);
    logic [31:0] ebcd;
    bit          eneg, eovf;
    int          lat;
    int          width;
    width = w8 ? 8 : 16;
    model(width, w8 ? 2 : 5, bin, sgn, ebcd, eneg, eovf);
    if (w8) begin start8 = 1'b1; bin8 = bin[7:0]; sgn8 = sgn; end
    else    begin start16 = 1'b1; bin16 = bin; sgn16 = sgn; end
    @(posedge clk); #1;
    start8 = 1'b0; start16 = 1'b0;
    check({tag, "_busy"}, {31'd0, w8 ? busy8 : busy16}, 32'd1);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (w8 ? done8 : done16) begin lat = n; break; end
    end
    check({tag, "_lat"}, lat, width);
    check({tag, "_bcd"}, w8 ? {24'd0, bcd8} : {12'd0, bcd16}, ebcd);
    check({tag, "_neg"}, {31'd0, w8 ? neg8 : neg16}, {31'd0, eneg});
    check({tag, "_ovf"}, {31'd0, w8 ? ovf8 : ovf16}, {31'd0, eovf});
    @(posedge clk); #1;
    check({tag, "_pulse"}, {31'd0, w8 ? done8 : done16}, 32'd0);
  endtask

  initial begin
    int cnt, first, dn0, dn1;
    logic [19:0] b0, b1;
    reset = 1'b1; start16 = 0; sgn16 = 0; bin16 = 0; start8 = 0; sgn8 = 0; bin8 = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", {27'd0, busy16, done16, neg16, ovf16, busy8}, 32'd0);
    check("rst_bcd", {4'd0, bcd16, bcd8}, 32'd0);
    check("rst_flags8", {29'd0, done8, neg8, ovf8}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_conv(0, 16'hFFFF, 0, "u_ffff");
    run_conv(0, 16'h8000, 1, "s_8000");
    run_conv(0, 16'hFFFF, 1, "s_ffff");
    run_conv(0, 16'h0000, 1, "s_0000");

    // start pulses mid-conversion must be ignored
    start16 = 1'b1; bin16 = 16'd1234; sgn16 = 1'b0;
    @(posedge clk); #1;
    start16 = 1'b0; bin16 = 16'd999;
    cnt = 0; first = 0; b0 = '0;
    for (int n = 1; n <= 40; n++) begin
      start16 = (n == 3) || (n == 10);
      @(posedge clk); #1;
      if (done16) begin
        cnt++;
        if (first == 0) begin first = n; b0 = bcd16; end
      end
    end
    start16 = 1'b0;
    check("ign_count", cnt, 1);
    check("ign_lat", first, 16);
    check("ign_bcd", {12'd0, b0}, 32'h01234);

    // start held through DONE: back-to-back conversions
    start16 = 1'b1; bin16 = 16'd1234;
    @(posedge clk); #1;
    bin16 = 16'd9;
    cnt = 0; dn0 = 0; dn1 = 0; b0 = '0; b1 = '0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (done16) begin
        if (cnt == 0) begin dn0 = n; b0 = bcd16; end
        else begin dn1 = n; b1 = bcd16; end
        cnt++;
        if (cnt == 2) begin start16 = 1'b0; break; end
      end
    end
    start16 = 1'b0;
    check("b2b_lat0", dn0, 16);
    check("b2b_gap", dn1 - dn0, 17);
    check("b2b_bcd0", {12'd0, b0}, 32'h01234);
    check("b2b_bcd1", {12'd0, b1}, 32'h00009);
    @(posedge clk); #1;

    // reset arriving at edge 8 aborts the conversion
    start16 = 1'b1; bin16 = 16'hFFFF; sgn16 = 1'b0;
    @(posedge clk); #1;
    start16 = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_out", {8'd0, bcd16, busy16, done16, neg16, ovf16}, 32'd0);
    reset = 1'b0;
    cnt = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk); #1;
      if (done16 || busy16) cnt++;
    end
    check("mid_rst_quiet", cnt, 0);
    run_conv(0, 16'hFFFF, 0, "post_rst");

    run_conv(1, 16'd255, 0, "w8_255");
    run_conv(1, 16'd99, 0, "w8_99");
    run_conv(1, 16'h0080, 1, "w8_s80");

    for (int i = 0; i < 25; i++)
      run_conv(0, 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), "rnd16");
    for (int i = 0; i < 15; i++)
      run_conv(1, 16'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), "rnd8");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
